// File: rtl/reaction_measurer_pkg.sv
// ==== reaction_measurer_pkg: shared round-state encodings and result ceiling (rev 1.0) ====
`default_nettype none

package reaction_measurer_pkg;

  localparam logic [2:0] STATE_IDLE           = 3'd0;
  localparam logic [2:0] STATE_WAIT           = 3'd1;
  localparam logic [2:0] STATE_GO             = 3'd2;
  localparam logic [2:0] STATE_RESULT_OK      = 3'd3;
  localparam logic [2:0] STATE_RESULT_EARLY   = 3'd4;
  localparam logic [2:0] STATE_RESULT_TIMEOUT = 3'd5;

  localparam logic [13:0] RT_CEIL = 14'd9999;

  function automatic logic is_result(input logic [2:0] s);
    return (s == STATE_RESULT_OK) || (s == STATE_RESULT_EARLY) ||
           (s == STATE_RESULT_TIMEOUT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ==== lfsr16: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11 (rev 1.0) ====
`default_nettype none

module lfsr16 (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic        fb;

  // Right-shifting form: taps 16,14,13,11 sit at bits 0,2,3,5.
  assign fb = value_q[0] ^ value_q[2] ^ value_q[3] ^ value_q[5];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) value_q <= 16'hACE1;
    else        value_q <= {fb, value_q[15:1]};
  end

  assign value = value_q;

endmodule

`default_nettype wire

// File: rtl/reaction_measurer.sv
// ==== reaction_measurer: random-delay go light and millisecond reaction timer (rev 1.0) ====
`default_nettype none

module reaction_measurer
  import reaction_measurer_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        button,
  output logic [2:0]  current_state,
  output logic [13:0] reaction_time,
  output logic        go_led,
  output logic        result_valid
);

  localparam int unsigned TICKS_PER_MS = CLK_HZ / 1000;
  localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int unsigned DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS) + 1);

  logic [15:0]   lfsr_val;
  logic          unused_lfsr;
  logic          sync1_q, sync2_q, prev_q, press_q, armed_q;
  logic [1:0]    vld_q;
  logic [PW-1:0] pre_q, pre_d;
  logic          ms_tick;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [13:0]   msc_q, msc_d;
  logic [13:0]   rt_q, rt_d;
  logic          go_q, rv_q;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_val)
  );

  assign unused_lfsr = ^lfsr_val;

  // armed_q stays low until the synchronised button has been seen released
  // after reset, so a button held across reset release never counts as a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= armed_q & sync2_q & ~prev_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~sync2_q);
    end
  end

  assign ms_tick = (pre_q == PW'(TICKS_PER_MS - 1));

  always_comb begin
    if ((state_d != state_q) || ms_tick) pre_d = '0;
    else                                 pre_d = pre_q + PW'(1);
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    msc_d   = msc_q;
    rt_d    = rt_q;
    case (state_q)
      STATE_WAIT: begin
        if (press_q) begin
          state_d = STATE_RESULT_EARLY;
          rt_d    = RT_CEIL;
        end else if (ms_tick) begin
          if (delay_q == DW'(1)) begin
            state_d = STATE_GO;
            msc_d   = '0;
          end else begin
            delay_d = delay_q - DW'(1);
          end
        end
      end
      STATE_GO: begin
        // A press on the timeout tick still reports the last counted value.
        if (press_q) begin
          state_d = STATE_RESULT_OK;
          rt_d    = msc_q;
        end else if (ms_tick) begin
          if (msc_q == RT_CEIL - 14'd1) begin
            state_d = STATE_RESULT_TIMEOUT;
            rt_d    = RT_CEIL;
          end else begin
            msc_d = msc_q + 14'd1;
          end
        end
      end
      default: begin
        if (press_q) begin
          state_d = STATE_WAIT;
          delay_d = DW'(MIN_DELAY_MS) + DW'(lfsr_val[RAND_BITS-1:0]);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      state_q <= STATE_IDLE;
      delay_q <= '0;
      msc_q   <= '0;
      rt_q    <= '0;
      go_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      delay_q <= delay_d;
      msc_q   <= msc_d;
      rt_q    <= rt_d;
      go_q    <= (state_d == STATE_GO);
      rv_q    <= is_result(state_d) & ~is_result(state_q);
    end
  end

  assign current_state = state_q;
  assign reaction_time = rt_q;
  assign go_led        = go_q;
  assign result_valid  = rv_q;

endmodule

`default_nettype wire

// File: tb/tb_reaction_measurer.sv
// ==== tb_reaction_measurer: timestamp-based model plus directed rounds on two instances (rev 1.0) ====
`default_nettype none

module tb_reaction_measurer;
  import reaction_measurer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  btn = 2'b00;
  logic [2:0]  st [2];
  logic [13:0] rt [2];
  logic        go [2];
  logic        rv [2];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Instance 0: 4 clocks per ms. Instance 1: 2 clocks per ms, used for the long timeout runs.
  reaction_measurer #(.CLK_HZ(4000), .MIN_DELAY_MS(2), .RAND_BITS(2)) dut (
    .clock(clk), .reset(rst_n), .button(btn[0]),
    .current_state(st[0]), .reaction_time(rt[0]), .go_led(go[0]), .result_valid(rv[0])
  );

  reaction_measurer #(.CLK_HZ(2000), .MIN_DELAY_MS(2), .RAND_BITS(2)) dut_fast (
    .clock(clk), .reset(rst_n), .button(btn[1]),
    .current_state(st[1]), .reaction_time(rt[1]), .go_led(go[1]), .result_valid(rv[1])
  );

  typedef struct packed {
    logic [2:0] st;
    int         entry;
    int         delay;
    int         rt;
    logic       rv;
    logic [3:0] bh;
  } mdl_t;

  mdl_t        m [2];
  int          n_edges;
  logic [15:0] m_lfsr;

  function automatic int tk(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Edge n (1 = first edge after reset release). A press acts 3 edges after the
  // button is first sampled high, provided the sample before it came after release.
  // Time inside a state is measured from its entry edge: k cycles elapsed.
  function automatic mdl_t step(input mdl_t s, input int i, input int n,
                                input logic b, input logic [15:0] lf);
    mdl_t r;
    int   k;
    int   t;
    logic p;
    r = s;
    t = tk(i);
    k = n - s.entry - 1;
    p = s.bh[2] & ~s.bh[3] & (n >= 5);
    r.rv = 1'b0;
    r.bh = {s.bh[2:0], b};
    case (s.st)
      STATE_WAIT: begin
        if (p) begin
          r.st = STATE_RESULT_EARLY; r.rt = 9999; r.rv = 1'b1;
        end else if (k + 1 == s.delay * t) begin
          r.st = STATE_GO; r.entry = n;
        end
      end
      STATE_GO: begin
        if (p) begin
          r.st = STATE_RESULT_OK; r.rt = k / t; r.rv = 1'b1;
        end else if (k + 1 == 9999 * t) begin
          r.st = STATE_RESULT_TIMEOUT; r.rt = 9999; r.rv = 1'b1;
        end
      end
      default: begin
        if (p) begin
          r.st = STATE_WAIT; r.entry = n; r.delay = 2 + int'(lf[1:0]);
        end
      end
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edges <= 0;
      m_lfsr  <= 16'hACE1;
      for (int i = 0; i < 2; i++) m[i] <= '{st: STATE_IDLE, entry: 0, delay: 0, rt: 0, rv: 1'b0, bh: 4'b0};
    end else begin
      for (int i = 0; i < 2; i++) m[i] <= step(m[i], i, n_edges + 1, btn[i], m_lfsr);
      n_edges <= n_edges + 1;
      m_lfsr  <= lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (st[i] !== m[i].st || rt[i] !== 14'(m[i].rt) ||
            go[i] !== (m[i].st == STATE_GO) || rv[i] !== m[i].rv) begin
          n_err++;
          $display("FAIL model_cmp[%0d] @%0t: state/rt/go/rv = %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                   i, $time, st[i], rt[i], go[i], rv[i],
                   m[i].st, m[i].rt, (m[i].st == STATE_GO), m[i].rv);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, required %0d", nm, $time, act, exp);
    end
  endtask

  task automatic wait_st(input int i, input logic [2:0] s, input int maxc,
                         input string nm, output int cyc);
    cyc = 0;
    while (st[i] !== s && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, int'(st[i]), int'(s));
  endtask

  task automatic wait_leave(input int i, input logic [2:0] s, input int maxc,
                            input string nm, output int cyc);
    cyc = 0;
    while (st[i] === s && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, int'(st[i] !== s), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int d;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_state%0d", i), int'(st[i]), int'(STATE_IDLE));
      chk($sformatf("reset_rt%0d", i), int'(rt[i]), 0);
      chk($sformatf("reset_go%0d", i), int'(go[i]), 0);
      chk($sformatf("reset_rv%0d", i), int'(rv[i]), 0);
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Round 1: normal reaction of 37 ms.
    btn[0] = 1'b1;
    wait_st(0, STATE_WAIT, 10, "enter_wait", c);
    chk("press_latency", c, 4);
    btn[0] = 1'b0;
    wait_st(0, STATE_GO, 30, "enter_go", c);
    chk("go_delay_2to5ms", int'((c % 4 == 0) && c >= 8 && c <= 20), 1);
    chk("go_led_on", int'(go[0]), 1);
    repeat (146) @(negedge clk);
    btn[0] = 1'b1;
    wait_leave(0, STATE_GO, 10, "go_exit", c);
    chk("ok_state", int'(st[0]), int'(STATE_RESULT_OK));
    chk("ok_rt37", int'(rt[0]), 37);
    chk("ok_go_off", int'(go[0]), 0);
    chk("ok_rv_pulse", int'(rv[0]), 1);
    @(negedge clk);
    chk("ok_rv_one_cycle", int'(rv[0]), 0);
    repeat (10) @(negedge clk);
    chk("held_no_retrigger", int'(st[0]), int'(STATE_RESULT_OK));
    btn[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Round 2: early press well inside WAIT; previous result held meanwhile.
    btn[0] = 1'b1;
    wait_st(0, STATE_WAIT, 10, "enter_wait2", c);
    chk("rt_kept_in_wait", int'(rt[0]), 37);
    btn[0] = 1'b0;
    repeat (2) @(negedge clk);
    btn[0] = 1'b1;
    wait_leave(0, STATE_WAIT, 10, "early_exit", c);
    chk("early_state", int'(st[0]), int'(STATE_RESULT_EARLY));
    chk("early_rt", int'(rt[0]), 9999);
    chk("early_rv", int'(rv[0]), 1);
    btn[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Round 3: press lands on the final WAIT tick.
    btn[0] = 1'b1;
    wait_st(0, STATE_WAIT, 10, "enter_wait3", c);
    btn[0] = 1'b0;
    d = m[0].delay;
    repeat (d * 4 - 4) @(negedge clk);
    btn[0] = 1'b1;
    wait_leave(0, STATE_WAIT, 10, "final_tick_exit", c);
    chk("final_tick_early", int'(st[0]), int'(STATE_RESULT_EARLY));
    chk("final_tick_rt", int'(rt[0]), 9999);
    chk("final_tick_go_off", int'(go[0]), 0);
    btn[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Round 4: reset mid-GO with the button held through release.
    btn[0] = 1'b1;
    wait_st(0, STATE_WAIT, 10, "enter_wait4", c);
    btn[0] = 1'b0;
    wait_st(0, STATE_GO, 30, "enter_go4", c);
    repeat (5) @(negedge clk);
    btn[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(st[0]), int'(STATE_IDLE));
    chk("async_rst_rt", int'(rt[0]), 0);
    chk("async_rst_go", int'(go[0]), 0);
    chk("async_rst_rv", int'(rv[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_through_reset", int'(st[0]), int'(STATE_IDLE));
    btn[0] = 1'b0;
    repeat (4) @(negedge clk);
    btn[0] = 1'b1;
    wait_st(0, STATE_WAIT, 10, "enter_wait5", c);
    chk("press_after_rerelease", c, 4);
    btn[0] = 1'b0;

    // Fast instance: full 9999 ms timeout, then a press on the timeout tick.
    btn[1] = 1'b1;
    wait_st(1, STATE_WAIT, 10, "f_enter_wait", c);
    btn[1] = 1'b0;
    wait_st(1, STATE_GO, 20, "f_enter_go", c);
    wait_leave(1, STATE_GO, 9999 * 2 + 10, "f_timeout_exit", c);
    chk("f_timeout_cycles", c, 19998);
    chk("f_timeout_state", int'(st[1]), int'(STATE_RESULT_TIMEOUT));
    chk("f_timeout_rt", int'(rt[1]), 9999);
    chk("f_timeout_rv", int'(rv[1]), 1);
    repeat (4) @(negedge clk);
    btn[1] = 1'b1;
    wait_st(1, STATE_WAIT, 10, "f_enter_wait2", c);
    btn[1] = 1'b0;
    wait_st(1, STATE_GO, 20, "f_enter_go2", c);
    repeat (9999 * 2 - 4) @(negedge clk);
    btn[1] = 1'b1;
    wait_leave(1, STATE_GO, 20, "f_last_tick_exit", c);
    chk("f_last_tick_state", int'(st[1]), int'(STATE_RESULT_OK));
    chk("f_last_tick_rt", int'(rt[1]), 9998);
    btn[1] = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
